// File: rtl/hc595_chain_ctrl.sv
// Commit-driven frame sequencer for a daisy chain of 74HC595s, fed from a per-chip shadow file.
// Define HC595_AUTO_REFRESH_EN to re-send the shadow file every REFRESH_PERIOD cycles.
module hc595_chain_ctrl #(
    parameter int NUM_CHIPS      = 2,
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_PERIOD = 1_200_000,
    localparam int AW            = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          commit,
    output logic          busy,
    output logic          frame_done,
    output logic          ds,
    output logic          sh_cp,
    output logic          st_cp,
    output logic [2:0]    dbg_state
);

    localparam int NBITS = 8 * NUM_CHIPS;
    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW    = $clog2(NBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BIT_LO   = 3'd1,
        BIT_HI   = 3'd2,
        LATCH_LO = 3'd3,
        LATCH_HI = 3'd4,
        DONE     = 3'd5
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bit_q;
    logic [NBITS-1:0] shreg_q;
    logic             pending_q;
    logic [7:0]       shadow_q [NUM_CHIPS];
    logic             busy_q;
    logic             frame_done_q;
    logic             ds_q;
    logic             sh_cp_q;
    logic             st_cp_q;

    logic [7:0]       shadow_d [NUM_CHIPS];
    logic [NBITS-1:0] snap_d;
    logic             half_end;
    logic             start;
    logic             refresh_hit;

    // Out-of-range addresses match no entry, so such writes simply fall away.
    // The snapshot is taken from the post-write view so a same-cycle write is included.
    always_comb begin
        snap_d = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_en && (int'(wr_addr) == i)) begin
                shadow_d[i] = wr_data;
            end
            snap_d[8*i +: 8] = shadow_d[i];
        end
    end

    assign half_end = (cnt_q == CNT_LAST);
    assign start    = (state_q == IDLE) && (commit || pending_q || refresh_hit);

`ifdef HC595_AUTO_REFRESH_EN
    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    logic [RW-1:0] refresh_q;

    assign refresh_hit = (refresh_q == RW'(REFRESH_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst || start || refresh_hit) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_q + RW'(1);
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            ds_q         <= 1'b0;
            sh_cp_q      <= 1'b0;
            st_cp_q      <= 1'b0;
            for (int i = 0; i < NUM_CHIPS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHIPS; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            if ((state_q != IDLE) && (commit || refresh_hit)) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q   <= snap_d;
                        ds_q      <= snap_d[NBITS-1];
                        cnt_q     <= '0;
                        bit_q     <= '0;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        sh_cp_q   <= 1'b0;
                        state_q   <= BIT_LO;
                    end
                end
                BIT_LO: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        sh_cp_q <= 1'b1;
                        state_q <= BIT_HI;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                BIT_HI: begin
                    if (half_end) begin
                        // ds moves together with the falling sh_cp, never while it is high.
                        cnt_q   <= '0;
                        sh_cp_q <= 1'b0;
                        if (bit_q == BIT_LAST) begin
                            ds_q    <= 1'b0;
                            state_q <= LATCH_LO;
                        end else begin
                            bit_q   <= bit_q + BW'(1);
                            shreg_q <= {shreg_q[NBITS-2:0], 1'b0};
                            ds_q    <= shreg_q[NBITS-2];
                            state_q <= BIT_LO;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                LATCH_LO: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        st_cp_q <= 1'b1;
                        state_q <= LATCH_HI;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                LATCH_HI: begin
                    if (half_end) begin
                        cnt_q        <= '0;
                        st_cp_q      <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign ds         = ds_q;
    assign sh_cp      = sh_cp_q;
    assign st_cp      = st_cp_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// Directed bench for hc595_chain_ctrl: a 2-chip/CLK_DIV=4 chain plus a 3-chip/CLK_DIV=1 chain.
// With HC595_AUTO_REFRESH_EN defined the 2-chip part runs the periodic refresh sequence instead.
`timescale 1ns/1ps
module tb_hc595_chain_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // 2-chip chain, CLK_DIV=4
    logic       wr_en = 1'b0;
    logic       wr_addr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       commit = 1'b0;
    logic       busy, frame_done, ds, sh_cp, st_cp;
    logic [2:0] dbg_state;

    // 3-chip chain, CLK_DIV=1
    logic       wr_en3 = 1'b0;
    logic [1:0] wr_addr3 = 2'd0;
    logic [7:0] wr_data3 = 8'h00;
    logic       commit3 = 1'b0;
    logic       busy3, fd3, ds3, sh3, st3;
    logic [2:0] dbg3;

    hc595_chain_ctrl #(.NUM_CHIPS(2), .CLK_DIV(4), .REFRESH_PERIOD(200)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .busy(busy), .frame_done(frame_done), .ds(ds),
        .sh_cp(sh_cp), .st_cp(st_cp), .dbg_state(dbg_state)
    );

    hc595_chain_ctrl #(.NUM_CHIPS(3), .CLK_DIV(1)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .commit(commit3), .busy(busy3), .frame_done(fd3), .ds(ds3),
        .sh_cp(sh3), .st_cp(st3), .dbg_state(dbg3)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / monitor (2-chip chain) ----------------
    logic [15:0] exp_q[$];
    logic [15:0] exp_word;
    logic        expect_abort = 1'b0;
    int frames_seen = 0, cyc = 0, idle_cnt = 0, last_gap = 0;
    int start_cyc = 0, last_period = 0, stray = 0;
    int acc_len = 0, acc_rises = 0, acc_st = 0, acc_stw = 0, acc_fd = 0;
    logic [15:0] acc_word = '0;
    logic busy_p = 1'b0, sh_p = 1'b0, st_p = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (busy) begin
            if (!busy_p) begin
                acc_len = 0; acc_rises = 0; acc_st = 0; acc_stw = 0; acc_fd = 0;
                acc_word = '0;
                last_gap = idle_cnt;
                last_period = cyc - start_cyc;
                start_cyc = cyc;
            end
            idle_cnt = 0;
            acc_len++;
            if (sh_cp && !sh_p) begin
                acc_word = {acc_word[14:0], ds};
                acc_rises++;
            end
            if (st_cp && !st_p) acc_st++;
            if (st_cp) acc_stw++;
            if (frame_done) acc_fd++;
        end else begin
            idle_cnt++;
            if ((sh_cp && !sh_p) || (st_cp && !st_p) || frame_done) stray++;
            if (busy_p) begin
                frames_seen++;
                if (expect_abort) begin
                    check("abort_st_pulses", acc_st, 0);
                    check("abort_done_pulses", acc_fd, 0);
                    expect_abort = 1'b0;
                end else if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("frame_data", acc_word, exp_word);
                    check("sh_rises", acc_rises, 16);
                    check("st_pulses", acc_st, 1);
                    check("st_width", acc_stw, 4);
                    check("busy_len", acc_len, 137);
                    check("done_pulses", acc_fd, 1);
                end
            end
        end
        busy_p = busy; sh_p = sh_cp; st_p = st_cp;
    end

    // ---------------- monitor (3-chip chain) ----------------
    int frames3 = 0, rises3 = 0, len3 = 0;
    logic [23:0] word3 = '0;
    logic busy3_p = 1'b0, sh3_p = 1'b0;

    always @(negedge clk) begin
        if (busy3) begin
            if (!busy3_p) begin
                word3 = '0; rises3 = 0; len3 = 0;
            end
            len3++;
            if (sh3 && !sh3_p) begin
                word3 = {word3[22:0], ds3};
                rises3++;
            end
        end else if (busy3_p) begin
            frames3++;
        end
        busy3_p = busy3; sh3_p = sh3;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic addr, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = addr; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic write_3(input logic [1:0] addr, input logic [7:0] d);
        wr_en3 = 1'b1; wr_addr3 = addr; wr_data3 = d;
        tick();
        wr_en3 = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, (frames_seen >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ds", ds, 0);
        check("rst_sh_cp", sh_cp, 0);
        check("rst_st_cp", st_cp, 0);
        rst = 1'b0;
        tick();

        // 3-chip chain: addr 2 lands on the far chip, addr 3 is dropped
        write_3(2'd2, 8'h5A);
        write_3(2'd1, 8'h11);
        write_3(2'd3, 8'hC3);
        commit3 = 1'b1; tick(); commit3 = 1'b0;
        n = 0;
        while (frames3 < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("chip3_frame_timeout", (frames3 >= 1) ? 32'd1 : 32'd0, 32'd1);
        check("chip3_data", word3, 24'h5A1100);
        check("chip3_rises", rises3, 24);
        check("chip3_busy_len", len3, 51);
        tick();

`ifdef HC595_AUTO_REFRESH_EN
        // Periodic refresh with no commits, then a commit restarting the interval
        write_a(1'b0, 8'h12);
        write_a(1'b1, 8'h34);
        repeat (4) exp_q.push_back(16'h3412);
        wait_frames(1, 600, "refresh1_timeout");
        wait_frames(2, 600, "refresh2_timeout");
        check("refresh_period", last_period, 200);
        repeat (10) tick();
        pulse_commit();
        wait_frames(3, 600, "commit_frame_timeout");
        check("commit_period_short", (last_period < 200) ? 32'd1 : 32'd0, 32'd1);
        wait_frames(4, 600, "refresh4_timeout");
        check("refresh_after_commit", last_period, 200);
`else
        // Basic frame: chip1 byte first, MSB first
        write_a(1'b0, 8'hA5);
        write_a(1'b1, 8'h3C);
        exp_q.push_back(16'h3CA5);
        pulse_commit();
        wait_frames(1, 400, "frame1_timeout");

        // Same-cycle write is included in the snapshot
        exp_q.push_back(16'hFFA5);
        wr_en = 1'b1; wr_addr = 1'b1; wr_data = 8'hFF; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        wait_frames(2, 400, "frame2_timeout");

        // Writes and commits during a frame coalesce into one follow-up frame
        exp_q.push_back(16'hFFA5);
        exp_q.push_back(16'hFF00);
        pulse_commit();
        repeat (10) tick();
        write_a(1'b0, 8'h00);
        repeat (5) tick();
        pulse_commit();
        repeat (5) tick();
        pulse_commit();
        repeat (5) tick();
        pulse_commit();
        wait_frames(4, 600, "followup_timeout");
        check("followup_gap", last_gap, 1);
        repeat (300) tick();
        check("no_extra_frame", frames_seen, 4);

        // Reset in the middle of bit 7 abandons the frame
        pulse_commit();
        n = 0;
        while (!(busy && acc_rises == 7) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("bit7_reached", acc_rises, 7);
        tick();
        expect_abort = 1'b1;
        rst = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_ds", ds, 0);
        check("midrst_sh_cp", sh_cp, 0);
        check("midrst_st_cp", st_cp, 0);
        rst = 1'b0;
        wait_frames(5, 10, "abort_seen");
        repeat (300) tick();
        check("no_frame_after_reset", frames_seen, 5);
        check("no_stray_edges", stray, 0);

        // Shadow was cleared by reset
        exp_q.push_back(16'h0000);
        pulse_commit();
        wait_frames(6, 400, "zero_frame_timeout");
`endif
        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
